// File: rtl/sadd_pipe.sv
// sadd_pipe: two-stage signed add/sub with overflow flag and saturating overflow counter; SADD_PIPE_SAT_EN clamps Result on overflow.
// Latency: 2 cycles from input transfer to OutValid, 1 beat/cycle sustained.
// Backpressure: InReady falls only when both stages hold beats and OutReady is low; a held output beat is stable.
module sadd_pipe #(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DATAWIDTH-1:0] A,
    input  logic [DATAWIDTH-1:0] B,
    input  logic                 Sub,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DATAWIDTH-1:0] Result,
    output logic                 Ovf,
    output logic [CNTWIDTH-1:0]  OvfCnt,
    input  logic                 ClrCnt
);

    localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);
    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    logic                 s1_vld_q, s1_vld_d;
    logic [DATAWIDTH-1:0] s1_a_q, s1_a_d;
    logic [DATAWIDTH-1:0] s1_b_q, s1_b_d;
    logic                 s1_sub_q, s1_sub_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [DATAWIDTH-1:0] s2_res_q, s2_res_d;
    logic                 s2_ovf_q, s2_ovf_d;
    logic [CNTWIDTH-1:0]  cnt_q, cnt_d;

    logic                 s2_adv, s1_adv, out_xfer;
    logic [DATAWIDTH:0]   a_ext, b_ext, sum_ext;
    logic                 ovf_calc;
    logic [DATAWIDTH-1:0] res_calc;

    assign s2_adv   = !s2_vld_q || OutReady;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign out_xfer = s2_vld_q && OutReady;

    assign InReady  = s1_adv;
    assign OutValid = s2_vld_q;
    assign Result   = s2_res_q;
    assign Ovf      = s2_ovf_q;
    assign OvfCnt   = cnt_q;

    // One extra bit makes the true sum representable; overflow shows as a sign-bit disagreement.
    always_comb begin
        a_ext    = {s1_a_q[DATAWIDTH-1], s1_a_q};
        b_ext    = {s1_b_q[DATAWIDTH-1], s1_b_q};
        sum_ext  = s1_sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf_calc = sum_ext[DATAWIDTH] != sum_ext[DATAWIDTH-1];
        res_calc = sum_ext[DATAWIDTH-1:0];
`ifdef SADD_PIPE_SAT_EN
        if (ovf_calc) begin
            res_calc = sum_ext[DATAWIDTH] ? {1'b1, {(DATAWIDTH-1){1'b0}}}
                                          : {1'b0, {(DATAWIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_sub_d = s1_sub_q;
        s2_vld_d = s2_vld_q;
        s2_res_d = s2_res_q;
        s2_ovf_d = s2_ovf_q;
        cnt_d    = cnt_q;

        if (s1_adv) begin
            s1_vld_d = InValid;
            if (InValid) begin
                s1_a_d   = A;
                s1_b_d   = B;
                s1_sub_d = Sub;
            end
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_res_d = res_calc;
                s2_ovf_d = ovf_calc;
            end
        end

        // Clear wins over a same-cycle increment.
        if (ClrCnt) begin
            cnt_d = '0;
        end else if (out_xfer && s2_ovf_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_sub_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_res_q <= '0;
            s2_ovf_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_sub_q <= s1_sub_d;
            s2_vld_q <= s2_vld_d;
            s2_res_q <= s2_res_d;
            s2_ovf_q <= s2_ovf_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sadd_pipe.sv
// Scoreboard bench for sadd_pipe (DATAWIDTH=8, CNTWIDTH=2); honours SADD_PIPE_SAT_EN in its model.
module tb_sadd_pipe;

    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    logic          Clk;
    logic          Rst;
    logic          InValid;
    logic          InReady;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          Sub;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] Result;
    logic          Ovf;
    logic [CW-1:0] OvfCnt;
    logic          ClrCnt;

    sadd_pipe #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .Sub      (Sub),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .Ovf      (Ovf),
        .OvfCnt   (OvfCnt),
        .ClrCnt   (ClrCnt)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_pop_cyc = 0;
    bit   lat_check = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, got, got, exp, exp, $time);
    endtask

    function automatic exp_t model(input int a, input int b, input bit sub);
        exp_t        e;
        int          r;
        logic [31:0] rv;
        r = sub ? (a - b) : (a + b);
        e.ovf = (r > MAXV) || (r < MINV);
`ifdef SADD_PIPE_SAT_EN
        if (r > MAXV) r = MAXV;
        else if (r < MINV) r = MINV;
`endif
        rv = r;
        e.res = rv[DW-1:0];
        e.cyc = 0;
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge Clk) begin
        if (Rst) begin
            if (InValid && InReady) begin
                exp_t e;
                e = model(int'($signed(A)), int'($signed(B)), Sub);
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", OutValid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", Result, e.res);
                    chk("ovf", Ovf, e.ovf);
                    if (lat_check) chk("latency", cyc - e.cyc, 2);
                    last_pop_cyc = cyc;
                end
            end
        end
    end

    task automatic tick(output bit acc);
        @(negedge Clk);
        acc = InValid && InReady;
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input bit sub);
        bit acc;
        int n;
        A = a[DW-1:0];
        B = b[DW-1:0];
        Sub = sub;
        InValid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        InValid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick(acc);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        bit acc;
        int n_acc;
        int rel_cyc;
        int n;

        Rst = 1'b0;
        InValid = 1'b0;
        A = '0;
        B = '0;
        Sub = 1'b0;
        OutReady = 1'b1;
        ClrCnt = 1'b0;

        #12;
        chk("rst_inready", InReady, 1'b1);
        chk("rst_outvalid", OutValid, 1'b0);
        chk("rst_result", Result, 0);
        chk("rst_ovf", Ovf, 1'b0);
        chk("rst_ovfcnt", OvfCnt, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Directed arithmetic and edge operands at full rate, latency checked per beat.
        lat_check = 1'b1;
        send(100, 27, 1'b0);
        send(100, 28, 1'b0);
        drain();
        chk("ovfcnt_one", OvfCnt, 1);
        send(-128, 1, 1'b1);
        send(0, -128, 1'b1);
        send(-128, -128, 1'b1);
        send(5, -3, 1'b1);
        send(-7, -9, 1'b0);
        drain();
        chk("ovfcnt_three", OvfCnt, 3);
        send(100, 28, 1'b0);
        send(-100, -29, 1'b0);
        drain();
        chk("ovfcnt_sat", OvfCnt, 3);
        lat_check = 1'b0;

        // Clear on the same cycle as an overflowing output transfer.
        OutReady = 1'b0;
        send(100, 28, 1'b0);
        InValid = 1'b0;
        n = 0;
        while (!OutValid && n < 10) begin
            tick(acc);
            n++;
        end
        chk("clr_beat_ready", OutValid, 1'b1);
        OutReady = 1'b1;
        ClrCnt = 1'b1;
        tick(acc);
        ClrCnt = 1'b0;
        chk("ovfcnt_clr", OvfCnt, 0);
        send(127, 1, 1'b0);
        drain();
        chk("ovfcnt_after_clr", OvfCnt, 1);

        // Backpressure: 5 beats i+i with the output stalled for 4 cycles.
        OutReady = 1'b0;
        n_acc = 0;
        A = DW'(1);
        B = DW'(1);
        Sub = 1'b0;
        InValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(acc);
            if (acc) begin
                n_acc++;
                A = DW'(n_acc + 1);
                B = DW'(n_acc + 1);
            end
            if (k >= 1) begin
                chk("stall_valid", OutValid, 1'b1);
                chk("stall_result", Result, 2);
            end
        end
        chk("stall_accepted", n_acc, 2);
        chk("stall_inready", InReady, 1'b0);
        OutReady = 1'b1;
        rel_cyc = cyc;
        for (int i = 3; i <= 5; i++) send(i, i, 1'b0);
        drain();
        chk("release_rate", last_pop_cyc - rel_cyc, 4);

        // Reset with both stages occupied.
        OutReady = 1'b0;
        send(1, 2, 1'b0);
        send(100, 28, 1'b0);
        InValid = 1'b0;
        chk("prerst_valid", OutValid, 1'b1);
        chk("prerst_inready", InReady, 1'b0);
        Rst = 1'b0;
        #1;
        chk("midrst_valid", OutValid, 1'b0);
        chk("midrst_ovfcnt", OvfCnt, 0);
        chk("midrst_inready", InReady, 1'b1);
        sb.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        OutReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(acc);
            chk("postrst_valid", OutValid, 1'b0);
        end
        send(3, 4, 1'b0);
        drain();
        chk("postrst_ovfcnt", OvfCnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sadd_pipe.md
# sadd_pipe

Parametrised, pipelined signed add/subtract unit with a valid/ready handshake, overflow detection, optional saturation and a saturating overflow event counter. It is the streaming successor to the plain combinational signed adder in the datapath component library. The datapath generator instantiates it wherever a signed ADD/SUB sits on a handshaked path and must tolerate backpressure.

## Interface
- DATAWIDTH, 8: operand/result width in bits, two's complement, ≥2
- CNTWIDTH, 8: width of overflow event counter, ≥1

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- InValid  in  1  operand beat valid
- InReady  out  1  unit can accept a beat this cycle
- A  in  DATAWIDTH  signed operand a
- B  in  DATAWIDTH  signed operand b
- Sub  in  1  0: A+B, 1: A−B
- OutValid  out  1  result beat valid
- OutReady  in  1  downstream accepts result
- Result  out  DATAWIDTH  signed result
- Ovf  out  1  overflow flag for the current Result beat
- OvfCnt  out  CNTWIDTH  number of accepted-output overflow events, saturating
- ClrCnt  in  1  synchronous clear of OvfCnt

## Operation
- Two register stages: S1 holds {A, B, Sub}; S2 holds {Result, Ovf}. Each stage has its own valid bit.
- Transfer in: InValid && InReady. Transfer out: OutValid && OutReady.
- S2 advances when !S2.valid || OutReady. S1 advances when !S1.valid || S2 advances. InReady = !S1.valid || S2 advances (combinational, no registered bubble).
- Arithmetic in S1→S2: extend A and B to DATAWIDTH+1 bits; compute A+B or A−B at DATAWIDTH+1.
- Ovf = bit[DATAWIDTH] != bit[DATAWIDTH−1] of the extended result.
- Result without saturation: low DATAWIDTH bits (wrap). Saturation behaviour: see Configuration.
- OvfCnt increments by 1 on each output transfer with Ovf=1. It holds at 2^CNTWIDTH−1.
- ClrCnt has priority over an increment in the same cycle; the counter becomes 0.
- No reordering, no dropping: output beats equal input beats in order.

## Timing
- Reset (Rst=0, asynchronous): S1.valid=0, S2.valid=0, OutValid=0, Result=0, Ovf=0, OvfCnt=0. InReady=1 once reset is released, and also during reset (derived from the cleared valids).
- Latency: 2 cycles from input transfer to OutValid when OutReady is held high.
- Throughput: 1 beat/cycle with OutReady=1.
- Backpressure:
  - With OutReady=0 and both stages full, InReady=0.
  - While OutValid=1 and OutReady=0, Result, Ovf and OutValid are stable.
  - A held output beat releases one slot per OutReady cycle.
- Simultaneous in/out transfer when full: legal. S2 drains, S1 moves to S2 and the new beat enters S1 in the same edge.
- Reset mid-operation: all in-flight beats are discarded, and no partial beat appears afterwards.
- Operand edge cases:
  - A = −2^(DATAWIDTH−1) with Sub=1 and B=−2^(DATAWIDTH−1) gives 0, no Ovf.
  - A=0, B=−2^(DATAWIDTH−1), Sub=1 overflows.

## Configuration
- SADD_PIPE_SAT_EN defined: when Ovf=1, Result clamps to +2^(DATAWIDTH−1)−1 on positive overflow (extended bit[DATAWIDTH]=0) and to −2^(DATAWIDTH−1) on negative overflow. Ovf and OvfCnt still report the event.
- SADD_PIPE_SAT_EN undefined: Result wraps (low DATAWIDTH bits). No clamp logic is synthesised.

## Test plan
- DATAWIDTH=8, OutReady=1, A=100, B=27, Sub=0 → Result=127, Ovf=0, OutValid exactly 2 cycles after input transfer.
- A=100, B=28, Sub=0 → Ovf=1, OvfCnt=1. Without SAT: Result=−128. With SAT_EN: Result=127.
- A=−128, B=1, Sub=1 → Ovf=1. Without SAT: Result=127. With SAT_EN: Result=−128. A=0, B=−128, Sub=1 → Ovf=1.
- Backpressure:
  - Stream 5 beats (1+1 … 5+5) with OutReady=0 for 4 cycles → InReady drops after 2 accepted beats and Result holds 2 while stalled.
  - Release OutReady → outputs 2,4,6,8,10 in order, 1 per cycle.
- Reset mid-stream: assert Rst=0 with both stages valid → OutValid=0, OvfCnt=0 immediately, no stale beat after release.
- CNTWIDTH=2: 5 overflowing beats → OvfCnt stops at 3. ClrCnt asserted on the cycle of a 6th overflow transfer → OvfCnt=0.
